// File: rtl/apb_pack_arbiter.sv
// Round-robin arbiter sharing one packet-FIFO write port among N_REQ producers.
// A write ctrl pack and its data pack are forwarded back to back; a watchdog closes stalled writes.
module apb_pack_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64,
    localparam int GW     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*32-1:0]  req_data,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_wen,
    output logic [31:0]          fifo_wdata,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 proto_err
);

    // state | meaning
    // IDLE  | no grant; arbitrate among valid requesters
    // CTRL  | granted requester owes a ctrl pack
    // DATA  | write ctrl forwarded; its data pack is owed (watchdog runs)
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CTRL = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          proto_err_q, proto_err_d;

    logic [31:0]   word;
    logic          vld;
    logic          acc;
    logic          found;
    logic [GW-1:0] cand;

    assign word      = req_data[int'(grant_q)*32 +: 32];
    assign vld       = req_valid[grant_q];
    assign acc       = (state_q != IDLE) && vld && !fifo_full;
    assign grant_id  = grant_q;
    assign busy      = (state_q != IDLE);
    assign proto_err = proto_err_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        wait_cnt_d  = wait_cnt_q;
        proto_err_d = 1'b0;
        req_ready   = '0;
        fifo_wen    = 1'b0;
        fifo_wdata  = word;
        found       = 1'b0;
        cand        = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    // search starts one past the last winner so every requester gets a turn
                    for (int k = 1; k <= N_REQ; k++) begin
                        cand = GW'((int'(rr_ptr_q) + k) % N_REQ);
                        if (!found && req_valid[cand]) begin
                            found   = 1'b1;
                            grant_d = cand;
                        end
                    end
                    rr_ptr_d = grant_d;
                    state_d  = CTRL;
                end
            end
            CTRL: begin
                if (acc) begin
                    req_ready[grant_q] = 1'b1;
                    if (word[0]) begin
                        proto_err_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        fifo_wen = 1'b1;
                        if (word[1]) begin
                            wait_cnt_d = '0;
                            state_d    = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            DATA: begin
                if (acc) begin
                    req_ready[grant_q] = 1'b1;
                    if (word[0]) begin
                        fifo_wen = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end else if (!vld && !fifo_full) begin
                    if (TIMEOUT != 0 && wait_cnt_q == CW'(TIMEOUT)) begin
                        // zero-data filler lets the APB master finish its decode
                        fifo_wen    = 1'b1;
                        fifo_wdata  = 32'h0000_0001;
                        proto_err_d = 1'b1;
                        state_d     = IDLE;
                    end else if (wait_cnt_q != CW'(TIMEOUT)) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= GW'(N_REQ - 1);
            grant_q     <= '0;
            wait_cnt_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            wait_cnt_q  <= wait_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_apb_pack_arbiter.sv
// Bench for apb_pack_arbiter: FIFO writes are checked against a queue of expected words,
// single-requester transactions come from a vector table, multi-cycle corners are hand sequenced.
module tb_apb_pack_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid;
    logic [N*32-1:0] req_data;
    logic          fifo_full = 1'b0;
    logic [N-1:0]  req_ready, req_ready_b;
    logic          fifo_wen, fifo_wen_b;
    logic [31:0]   fifo_wdata, fifo_wdata_b;
    logic [1:0]    grant_id, grant_id_b;
    logic          busy, busy_b, proto_err, proto_err_b;

    logic          tb_v [N];
    logic [31:0]   tb_d [N];

    int            n_vec = 0;
    int            n_bad = 0;
    int            pe_cnt = 0;
    logic [31:0]   exp_q [$];

    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = tb_v[i];
            req_data[i*32 +: 32] = tb_d[i];
        end
    end

    apb_pack_arbiter #(.N_REQ(N), .TIMEOUT(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wen(fifo_wen),
        .fifo_wdata(fifo_wdata), .grant_id(grant_id), .busy(busy), .proto_err(proto_err)
    );

    apb_pack_arbiter #(.N_REQ(N), .TIMEOUT(0)) u_dut_nowd (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready_b), .fifo_full(fifo_full), .fifo_wen(fifo_wen_b),
        .fifo_wdata(fifo_wdata_b), .grant_id(grant_id_b), .busy(busy_b), .proto_err(proto_err_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard: every FIFO write must match the next expected word
    always @(negedge clk) begin
        if (rst_n) begin
            if (proto_err) pe_cnt++;
            if (fifo_full) chk("wen_while_full", {31'b0, fifo_wen}, 32'd0);
            if (fifo_wen) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_write: got %h, expected no write (t=%0t)", fifo_wdata, $time);
                end else begin
                    chk("fifo_wdata", fifo_wdata, exp_q.pop_front());
                end
            end
        end
    end

    // called just after a rising edge; returns just after the edge that consumed the word
    task automatic send(input int i, input logic [31:0] w);
        int n;
        n = 0;
        tb_v[i] = 1'b1;
        tb_d[i] = w;
        while (1) begin
            @(negedge clk);
            if (req_ready[i]) break;
            n++;
            if (n > 200) begin
                n_vec++;
                n_bad++;
                $display("FAIL send_timeout: req %0d word %h never accepted", i, w);
                break;
            end
        end
        @(posedge clk);
        #1;
        tb_v[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            tb_v[i] = 1'b0;
            tb_d[i] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int               req;
        int               n_w;
        logic [2:0][31:0] w;
        int               n_exp;
        logic [2:0][31:0] e;
        int               n_err;
    } vec_t;

    function automatic vec_t mk(int r, int nw, logic [31:0] a, logic [31:0] b, logic [31:0] c,
                                int ne, logic [31:0] x, logic [31:0] y, int err);
        vec_t v;
        v.req = r; v.n_w = nw; v.w[0] = a; v.w[1] = b; v.w[2] = c;
        v.n_exp = ne; v.e[0] = x; v.e[1] = y; v.e[2] = 32'h0; v.n_err = err;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl [4];
        int   pe0;
        logic seen;

        tbl[0] = mk(1, 1, 32'h0000_1204, 32'h0, 32'h0, 1, 32'h0000_1204, 32'h0, 0);
        tbl[1] = mk(3, 2, 32'h0000_5606, 32'h1234_5679, 32'h0, 2, 32'h0000_5606, 32'h1234_5679, 0);
        tbl[2] = mk(2, 1, 32'h0000_0003, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1);
        tbl[3] = mk(0, 3, 32'h0000_7806, 32'h0000_9904, 32'h0000_0011, 2, 32'h0000_7806, 32'h0000_0011, 1);

        // reset state
        do_reset();
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_grant", {30'b0, grant_id}, 0);
        chk("rst_proto_err", {31'b0, proto_err}, 0);
        chk("rst_wen", {31'b0, fifo_wen}, 0);
        chk("rst_ready", {28'b0, req_ready}, 0);

        // read ctrl from req1: write one cycle after arbitration, busy drops after
        @(posedge clk); #1;
        tb_v[1] = 1'b1; tb_d[1] = 32'h0000_1204;
        exp_q.push_back(32'h0000_1204);
        @(negedge clk);
        chk("t1_idle_wen", {31'b0, fifo_wen}, 0);
        @(posedge clk); @(negedge clk);
        chk("t1_grant", {30'b0, grant_id}, 1);
        chk("t1_busy", {31'b0, busy}, 1);
        chk("t1_wen", {31'b0, fifo_wen}, 1);
        @(posedge clk); #1;
        tb_v[1] = 1'b0;
        @(negedge clk);
        chk("t1_busy_drop", {31'b0, busy}, 0);

        // table of single-requester transactions
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pe0 = pe_cnt;
            for (int j = 0; j < tbl[i].n_exp; j++) exp_q.push_back(tbl[i].e[j]);
            for (int j = 0; j < tbl[i].n_w; j++) send(tbl[i].req, tbl[i].w[j]);
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("vec%0d_grant", i), {30'b0, grant_id}, 32'(tbl[i].req));
            chk($sformatf("vec%0d_busy", i), {31'b0, busy}, 0);
            chk($sformatf("vec%0d_errs", i), 32'(pe_cnt - pe0), 32'(tbl[i].n_err));
        end

        // atomic write: req0 write with late data, req2 read queued behind it
        do_reset();
        exp_q.push_back(32'h0000_1206);
        exp_q.push_back(32'h0000_ABCD);
        exp_q.push_back(32'h0000_3408);
        fork
            begin
                send(0, 32'h0000_1206);
                repeat (3) @(posedge clk);
                #1;
                send(0, 32'h0000_ABCD);
            end
            send(2, 32'h0000_3408);
        join
        repeat (2) @(posedge clk);
        #1;
        chk("t2_drained", 32'(exp_q.size()), 0);

        // round robin: all four hold read ctrls
        do_reset();
        for (int i = 0; i < N; i++) begin
            tb_v[i] = 1'b1;
            tb_d[i] = 32'h0001_0000 | (32'(i) << 8);
        end
        for (int k = 0; k < 6; k++) exp_q.push_back(32'h0001_0000 | (32'(k % 4) << 8));
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("t3_grant%0d", k), {30'b0, grant_id}, 32'(k % 4));
            chk($sformatf("t3_ready%0d", k), {28'b0, req_ready}, 32'(1 << (k % 4)));
            chk($sformatf("t3_wen%0d", k), {31'b0, fifo_wen}, 1);
            @(posedge clk); @(negedge clk);
            chk($sformatf("t3_gap%0d", k), {31'b0, fifo_wen}, 0);
        end
        for (int i = 0; i < N; i++) tb_v[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // backpressure during DATA
        do_reset();
        tb_v[0] = 1'b1; tb_d[0] = 32'h0000_1206;
        exp_q.push_back(32'h0000_1206);
        exp_q.push_back(32'h0000_ABCD);
        @(posedge clk); @(posedge clk); #1;
        tb_d[0] = 32'h0000_ABCD;
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t4_wen_full%0d", k), {31'b0, fifo_wen}, 0);
            chk($sformatf("t4_ready_full%0d", k), {28'b0, req_ready}, 0);
            @(posedge clk);
        end
        #1;
        fifo_full = 1'b0;
        @(negedge clk);
        chk("t4_wen_release", {31'b0, fifo_wen}, 1);
        chk("t4_ready_release", {28'b0, req_ready}, 1);
        @(posedge clk); #1;
        tb_v[0] = 1'b0;
        @(negedge clk);
        chk("t4_busy", {31'b0, busy}, 0);

        // watchdog: TIMEOUT=8 instance fills in, TIMEOUT=0 instance keeps waiting
        do_reset();
        tb_v[0] = 1'b1; tb_d[0] = 32'h0000_1206;
        exp_q.push_back(32'h0000_1206);
        exp_q.push_back(32'h0000_0001);
        @(posedge clk); @(posedge clk); #1;
        tb_v[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("t5_wait%0d", k), {31'b0, fifo_wen}, 0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("t5_filler_wen", {31'b0, fifo_wen}, 1);
        chk("t5_filler_ready", {28'b0, req_ready}, 0);
        @(posedge clk); @(negedge clk);
        chk("t5_proto_err", {31'b0, proto_err}, 1);
        chk("t5_busy", {31'b0, busy}, 0);
        chk("t5_nowd_err", {31'b0, proto_err_b}, 0);
        @(posedge clk); @(negedge clk);
        chk("t5_err_pulse", {31'b0, proto_err}, 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_wen_b) seen = 1'b1;
        end
        chk("t5_nowd_no_filler", {31'b0, seen}, 0);
        chk("t5_nowd_busy", {31'b0, busy_b}, 1);

        // orphan data pack in CTRL, then reset in the middle of a write
        do_reset();
        pe0 = pe_cnt;
        tb_v[0] = 1'b1; tb_d[0] = 32'h0000_0003;
        @(posedge clk); @(negedge clk);
        chk("t6_orphan_ready", {28'b0, req_ready}, 1);
        chk("t6_orphan_wen", {31'b0, fifo_wen}, 0);
        @(posedge clk); #1;
        tb_v[0] = 1'b0;
        @(negedge clk);
        chk("t6_orphan_err", {31'b0, proto_err}, 1);
        chk("t6_orphan_idle", {31'b0, busy}, 0);
        @(posedge clk); #1;
        exp_q.push_back(32'h0000_1206);
        send(1, 32'h0000_1206);
        chk("t6_in_data", {31'b0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", {31'b0, busy}, 0);
        tb_v[0] = 1'b1; tb_d[0] = 32'h0000_2004;
        tb_v[2] = 1'b1; tb_d[2] = 32'h0000_2204;
        exp_q.push_back(32'h0000_2004);
        exp_q.push_back(32'h0000_2204);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("t6_first_grant", {30'b0, grant_id}, 0);
        @(posedge clk); #1;
        tb_v[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("t6_second_grant", {30'b0, grant_id}, 2);
        @(posedge clk); #1;
        tb_v[2] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("final_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
